// File: rtl/set_multi.sv
// set_multi: generalised circle-set candidate counter.
// Loads NCIRC circles, scans every grid point (1..GRID)^2, tests membership
// in each circle one (point, circle) pair per cycle, and counts the points
// whose masked membership vector satisfies the selected set operation.
module set_multi #(
  parameter int NCIRC = 4,
  parameter int GRID  = 8,
  parameter int CW    = 4,
  parameter int KW    = 3,
  parameter int CNT_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NCIRC*2*CW-1:0]   central,
  input  logic [NCIRC*CW-1:0]     radius,
  input  logic [1:0]              mode,
  input  logic [NCIRC-1:0]        mask,
  input  logic [KW-1:0]           k,
  output logic                    busy,
  output logic                    valid,
  output logic [CNT_W-1:0]        candidate
);

  localparam int CIW = (NCIRC > 1) ? $clog2(NCIRC) : 1;
  localparam int SW  = 2 * CW + 3;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [NCIRC*2*CW-1:0] central_q;
  logic [NCIRC*CW-1:0]   radius_q;
  logic [1:0]            mode_q;
  logic [NCIRC-1:0]      mask_q;
  logic [KW-1:0]         k_q;

  logic [CW-1:0]         px, py;
  logic [CIW-1:0]        ci;
  logic [NCIRC-1:0]      hit_q;

  logic [CW-1:0]         cx [NCIRC];
  logic [CW-1:0]         cy [NCIRC];
  logic [CW-1:0]         cr [NCIRC];

  logic [SW-1:0]         sum;
  logic [2*CW-1:0]       rr;
  logic                  hit;
  logic [NCIRC-1:0]      v_raw, v;
  logic                  last_ci, last_pair, accept, match;

  // Squared distance along one axis; the difference needs a sign bit, the
  // square is never negative so it is returned as an unsigned value.
  function automatic logic [2*CW+1:0] sq_diff(input logic [CW-1:0] p,
                                               input logic [CW-1:0] c);
    logic signed [CW:0]     d;
    logic signed [2*CW+1:0] d2;
    d  = $signed({1'b0, p}) - $signed({1'b0, c});
    d2 = d * d;
    return d2;
  endfunction

  function automatic logic [KW-1:0] popcount(input logic [NCIRC-1:0] bits);
    logic [KW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NCIRC; i++) cnt = cnt + KW'(bits[i]);
    return cnt;
  endfunction

  // Set-operation test on the masked vector; an empty mask never counts.
  function automatic logic set_match(input logic [NCIRC-1:0] vec,
                                     input logic [NCIRC-1:0] msk,
                                     input logic [1:0]       md,
                                     input logic [KW-1:0]    kk);
    logic ok;
    case (md)
      2'b00:   ok = (vec == msk);
      2'b01:   ok = |vec;
      2'b10:   ok = ^vec;
      default: ok = (popcount(vec) == kk);
    endcase
    return ok & (|msk);
  endfunction

  for (genvar g = 0; g < NCIRC; g++) begin : g_unpack
    assign cx[g] = central_q[(NCIRC-g)*2*CW-1 -: CW];
    assign cy[g] = central_q[(NCIRC-g)*2*CW-CW-1 -: CW];
    assign cr[g] = radius_q[(NCIRC-g)*CW-1 -: CW];
  end

  assign accept    = (state == IDLE) && en;
  assign last_ci   = (ci == CIW'(NCIRC - 1));
  assign last_pair = last_ci && (px == CW'(GRID)) && (py == CW'(GRID));

  // Membership test for the current (point, circle) pair.
  always_comb begin
    sum = {1'b0, sq_diff(px, cx[ci])} + {1'b0, sq_diff(py, cy[ci])};
    rr  = cr[ci] * cr[ci];
    hit = (sum <= {3'b000, rr});
  end

  // Membership vector: stored hits for earlier circles, live hit for this one.
  always_comb begin
    v_raw = '0;
    for (int i = 0; i < NCIRC; i++) v_raw[i] = (CIW'(i) == ci) ? hit : hit_q[i];
    v     = v_raw & mask_q;
    match = set_match(v, mask_q, mode_q, k_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = SCAN;
      SCAN:    if (last_pair) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy  = (state == SCAN);
    valid = (state == DONE);
  end

  // Configuration capture at the accept edge only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      mask_q    <= '0;
      k_q       <= '0;
    end else if (accept) begin
      central_q <= central;
      radius_q  <= radius;
      mode_q    <= mode;
      mask_q    <= mask;
      k_q       <= k;
    end
  end

  // Scan counters, hit vector and candidate accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px        <= '0;
      py        <= '0;
      ci        <= '0;
      hit_q     <= '0;
      candidate <= '0;
    end else if (accept) begin
      px        <= CW'(1);
      py        <= CW'(1);
      ci        <= '0;
      hit_q     <= '0;
      candidate <= '0;
    end else if (state == SCAN) begin
      hit_q[ci] <= hit;
      if (last_ci) begin
        ci <= '0;
        if (match) candidate <= candidate + CNT_W'(1);
        if (px == CW'(GRID)) begin
          px <= CW'(1);
          py <= py + CW'(1);
        end else begin
          px <= px + CW'(1);
        end
      end else begin
        ci <= ci + CIW'(1);
      end
    end
  end

endmodule

// File: tb/tb_set_multi.sv
// Bench for set_multi: point-counting reference model plus directed runs.
module tb_set_multi;

  localparam int NCIRC = 4;
  localparam int GRID  = 8;
  localparam int CW    = 4;
  localparam int KW    = 3;
  localparam int CNT_W = 7;
  localparam int NPAIR = GRID * GRID * NCIRC;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en  = 1'b0;
  logic [NCIRC*2*CW-1:0] central = '0;
  logic [NCIRC*CW-1:0]   radius  = '0;
  logic [1:0]            mode    = '0;
  logic [NCIRC-1:0]      mask    = '0;
  logic [KW-1:0]         k       = '0;
  logic                  busy, valid;
  logic [CNT_W-1:0]      candidate;

  int cfg_x [NCIRC];
  int cfg_y [NCIRC];
  int cfg_r [NCIRC];

  int n_checks = 0;
  int n_fail   = 0;

  set_multi #(.NCIRC(NCIRC), .GRID(GRID), .CW(CW), .KW(KW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .mode(mode), .mask(mask), .k(k), .busy(busy), .valid(valid),
    .candidate(candidate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Direct count over the grid from the circle definitions.
  function automatic int model_count(input logic [1:0] md, input logic [NCIRC-1:0] mk, input int kk);
    int total, members, nmask, dx, dy;
    bit ok;
    total = 0;
    nmask = 0;
    for (int i = 0; i < NCIRC; i++) if (mk[i]) nmask++;
    for (int y = 1; y <= GRID; y++) begin
      for (int x = 1; x <= GRID; x++) begin
        members = 0;
        for (int i = 0; i < NCIRC; i++) begin
          dx = x - cfg_x[i];
          dy = y - cfg_y[i];
          if (mk[i] && (dx * dx + dy * dy <= cfg_r[i] * cfg_r[i])) members++;
        end
        case (md)
          2'b00:   ok = (members == nmask);
          2'b01:   ok = (members > 0);
          2'b10:   ok = (members % 2 == 1);
          default: ok = (members == kk);
        endcase
        if (nmask == 0) ok = 1'b0;
        if (ok) total++;
      end
    end
    return total;
  endfunction

  // Cycle-level expectation: idle / scanning for NPAIR edges / one done cycle.
  int m_phase  = 0;
  int m_cnt    = 0;
  int m_result = 0;
  int m_held   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_held  <= 0;
    end else begin
      case (m_phase)
        0: if (en) begin
             m_phase  <= 1;
             m_cnt    <= 0;
             m_result <= model_count(mode, mask, int'(k));
             m_held   <= 0;
           end
        1: begin
             m_cnt <= m_cnt + 1;
             if (m_cnt == NPAIR - 1) m_phase <= 2;
           end
        default: begin
             m_phase <= 0;
             m_held  <= m_result;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_phase == 1));
    chk("valid", int'(valid), int'(m_phase == 2));
    if (m_phase == 2)      chk("cand_final", int'(candidate), m_result);
    else if (m_phase == 0) chk("cand_hold", int'(candidate), m_held);
  end

  task automatic set_circle(input int i, input int x, input int y, input int r);
    cfg_x[i] = x;
    cfg_y[i] = y;
    cfg_r[i] = r;
  endtask

  task automatic drive_cfg(input logic [1:0] md, input logic [NCIRC-1:0] mk, input int kk);
    logic [CW-1:0] bx, by, br;
    for (int i = 0; i < NCIRC; i++) begin
      bx = CW'(cfg_x[i]);
      by = CW'(cfg_y[i]);
      br = CW'(cfg_r[i]);
      central[(NCIRC-i)*2*CW-1 -: 2*CW] = {bx, by};
      radius[(NCIRC-i)*CW-1 -: CW]      = br;
    end
    mode = md;
    mask = mk;
    k    = KW'(kk);
  endtask

  // Pulse en for one cycle; returns #1 after the accepting edge.
  task automatic start(input logic [1:0] md, input logic [NCIRC-1:0] mk, input int kk);
    @(posedge clk); #1;
    drive_cfg(md, mk, kk);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Returns #1 after the edge that raises valid; lat = edges since return of start.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run(input string name, input logic [1:0] md, input logic [NCIRC-1:0] mk,
                     input int kk, input int exp);
    int lat;
    start(md, mk, kk);
    wait_valid(lat);
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: valid not seen within 400 cycles", name);
    end else begin
      chk({name, "_cand"}, int'(candidate), exp);
      chk({name, "_lat"}, lat, NPAIR);
      chk({name, "_model"}, m_result, exp);
    end
  endtask

  initial begin
    int lat, pulses;
    for (int i = 0; i < NCIRC; i++) set_circle(i, 0, 0, 0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_cand", int'(candidate), 0);
    rst = 1'b1;

    // Single circle, point radius and whole-grid radius.
    set_circle(0, 4, 4, 0);
    run("c1_r0", 2'b01, 4'b0001, 0, 1);
    set_circle(0, 4, 4, 15);
    run("c1_r15", 2'b01, 4'b0001, 0, 64);

    // Two overlapping unit circles in the corner.
    set_circle(0, 1, 1, 1);
    set_circle(1, 2, 1, 1);
    run("c2_and", 2'b00, 4'b0011, 0, 2);
    run("c2_or", 2'b01, 4'b0011, 0, 5);
    run("c2_xor", 2'b10, 4'b0011, 0, 3);
    run("c2_k2", 2'b11, 4'b0011, 2, 2);
    run("c2_k1", 2'b11, 4'b0011, 1, 3);
    run("k_big", 2'b11, 4'b1111, 5, 0);

    // Empty mask never counts, including mode 00 and k=0.
    run("m0_and", 2'b00, 4'b0000, 0, 0);
    run("m0_or", 2'b01, 4'b0000, 0, 0);
    run("m0_xor", 2'b10, 4'b0000, 0, 0);
    run("m0_k0", 2'b11, 4'b0000, 0, 0);
    set_circle(0, 2, 1, 1);
    run("same_xor", 2'b10, 4'b0011, 0, 0);
    set_circle(0, 1, 1, 1);

    // en during a scan with another config is ignored.
    start(2'b01, 4'b0011, 0);
    repeat (99) @(posedge clk);
    #1;
    drive_cfg(2'b00, 4'b0001, 0);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    wait_valid(lat);
    chk("busy_en_cand", int'(candidate), 5);
    chk("busy_en_lat", lat, NPAIR - 100);
    @(posedge clk); #1;
    chk("busy_en_single", int'(valid), 0);

    // Reset mid-scan aborts without a valid pulse.
    start(2'b10, 4'b0011, 0);
    repeat (150) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_cand", int'(candidate), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    run("after_abort", 2'b10, 4'b0011, 0, 3);

    // Back-to-back: en in the cycle right after valid.
    run("b2b_first", 2'b01, 4'b0011, 0, 5);
    @(posedge clk); #1;
    chk("b2b_held", int'(candidate), 5);
    chk("b2b_idle", int'(busy), 0);
    drive_cfg(2'b00, 4'b0011, 0);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_clear", int'(candidate), 0);
    wait_valid(lat);
    chk("b2b_second", int'(candidate), 2);
    chk("b2b_lat", lat, NPAIR);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
